instruction_loader: RTL and testbench
=====================================

Name: instruction_loader

Overview:
- Writable instruction store for the 5-stage ARM-style core. Replaces the hard-coded ROM image with a RAM that is filled at run time from a byte stream (UART/JTAG bridge).
- Accepts bytes over a valid/ready handshake and packs them little-endian into 32-bit words. Each word is written at consecutive word addresses starting from 0.
- Holds the core stalled while loading. Serves fetches exactly as the ROM did: inst = mem[pc >> 2].

Parameters:
- DEPTH, 64, number of 32-bit words stored.
- ADDR_W, 6, word-address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc  input  32  fetch byte address from the IF stage.
- inst  output  32  instruction at word pc[ADDR_W+1:2]; combinational read.
- load_start  input  1  single-cycle pulse; begins or restarts a load at word 0.
- load_end  input  1  single-cycle pulse; terminates the load.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- cpu_hold  output  1  stall/hold request to the core while loading.
- load_done  output  1  one-cycle pulse when a load completes.
- load_err  output  1  sticky; the last load ended with a partial word.
- word_count  output  ADDR_W+1  words written by the current/last load.

Behaviour:
- Reset values (async, rst_n=0): state IDLE, byte_ready=0, cpu_hold=0, load_done=0, load_err=0, word_count=0, byte lane counter=0, shift register=0. RAM contents are not reset.
- Byte transfer occurs when byte_valid && byte_ready at a rising edge.
- FSM:
  - IDLE: byte_ready=0, cpu_hold=0. load_start goes to LOAD, clears word_count, lane and load_err.
  - LOAD: byte_ready=1, cpu_hold=1.
    - Each transfer places byte_in into lane (lane 0 = bits 7:0, lane 3 = bits 31:24) and increments lane mod 4.
    - On the 4th byte, the assembled word is written to mem[word_count] in the same edge and word_count increments.
  - LOAD exits to DONE on load_end, or automatically when word_count reaches DEPTH.
  - DONE: single cycle. load_done=1, byte_ready=0, cpu_hold=1. Next state is IDLE.
- Full boundary: the write of word DEPTH-1 moves the FSM to DONE on the same edge. byte_ready is 0 from the next cycle, and further bytes are not accepted.
- load_end with lane≠0: the partial word is discarded (no write) and load_err is set. load_err stays set until the next load_start or reset.
- Simultaneous load_end and transfer: the byte is accepted first. The partial-word check uses the lane value after that byte is counted. A 4th byte plus load_end therefore writes the word and gives no error.
- load_start while in LOAD: restart. word_count=0, lane=0, load_err=0, shift register cleared. Any byte transferring in that same cycle is dropped. Words already written stay in RAM.
- load_start in DONE: ignored. load_end in IDLE: ignored.
- Reset mid-load: returns to IDLE immediately and cpu_hold drops. Words written so far remain in RAM.
- Read path:
  - inst = mem[pc[ADDR_W+1:2]]. pc bits above ADDR_W+1 are ignored, so addresses wrap.
  - A write is visible on inst from the cycle after the write edge.
  - Never-written words read X in simulation. The bench pre-loads before any comparison.
- Latency: first word written 4 accepted bytes after entering LOAD. load_done follows the terminating edge by one cycle.

Decomposition:
- Shared package: state encoding constants (S_IDLE, S_LOAD, S_DONE), default DEPTH, and the NOP encoding 32'hE1A00000 for benches.
- One sub-module: inst_ram. Single write port, asynchronous read, DEPTH x 32, no reset. The top level holds the FSM, byte packer and counters.

Test Plan:
- Reset then load_start, bytes 14,00,A0,E3 then load_end -> mem[0]=32'hE3A00014, word_count=1, load_done pulses once, load_err=0, inst=E3A00014 at pc=0.
- Load 8 bytes (words E3A00014, E3A01A01) with byte_valid toggling every other cycle -> inst at pc=4 is E3A01A01, word_count=2, cpu_hold high from the cycle after load_start through DONE.
- Send 6 bytes then load_end -> word_count=1, load_err=1, mem[1] unchanged, load_done pulses.
- Stream 4*DEPTH+4 bytes without load_end -> auto DONE after byte 256; byte_ready=0 for remaining bytes; word_count=64; mem[63] holds bytes 253..256.
- Mid-load: after 2 words, pulse load_start with byte_valid high -> that byte dropped, word_count=0; next 4 bytes overwrite mem[0].
- Assert rst_n=0 during LOAD -> outputs return to reset values asynchronously; earlier-written words still readable via pc.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the run-time loadable instruction store.
package instruction_loader_pkg;

    localparam int DEPTH_DEFAULT  = 64;
    localparam int ADDR_W_DEFAULT = 6;

    // ARM "mov r0, r0", handy as a filler word when building images.
    localparam logic [31:0] NOP = 32'hE1A00000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/instruction_loader_inst_ram.sv
// DEPTH x 32 instruction RAM: one synchronous write port, asynchronous read,
// contents deliberately not reset so a reset never wipes a loaded program.
module instruction_loader_inst_ram
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Word write from the byte packer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_loader.sv
// Byte-stream loader for the instruction RAM. Packs bytes little-endian into
// words written at consecutive addresses from 0, stalls the core while
// loading, and serves fetches as inst = mem[pc >> 2].
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     pc,
    output logic [31:0]     inst,
    input  logic            load_start,
    input  logic            load_end,
    input  logic [7:0]      byte_in,
    input  logic            byte_valid,
    output logic            byte_ready,
    output logic            cpu_hold,
    output logic            load_done,
    output logic            load_err,
    output logic [ADDR_W:0] word_count
);

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] WC_ONE    = (ADDR_W + 1)'(1);

    state_t      state;
    logic [1:0]  lane;
    logic [1:0]  lane_after;
    logic [31:0] shift;
    logic        accept;
    logic        word_we;
    logic [31:0] word_data;
    logic        pc_unused;

    // A restart pulse wins over a byte offered in the same cycle: that byte is dropped.
    assign accept     = (state == S_LOAD) && byte_ready && byte_valid && !load_start;
    assign word_we    = accept && (lane == 2'd3);
    assign word_data  = {byte_in, shift[23:0]};
    assign lane_after = accept ? lane + 2'd1 : lane;

    // Only the word index bits of pc select; the rest wrap.
    assign pc_unused  = ^{pc[31:ADDR_W+2], pc[1:0]};

    // Control FSM, byte packer and word counter with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
            lane       <= '0;
            shift      <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        state      <= S_LOAD;
                        byte_ready <= 1'b1;
                        cpu_hold   <= 1'b1;
                        word_count <= '0;
                        lane       <= '0;
                        shift      <= '0;
                        load_err   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (load_start) begin
                        word_count <= '0;
                        lane       <= '0;
                        shift      <= '0;
                        load_err   <= 1'b0;
                    end else begin
                        if (accept) begin
                            shift[{lane, 3'b000} +: 8] <= byte_in;
                            lane                       <= lane_after;
                        end
                        if (word_we) begin
                            word_count <= word_count + WC_ONE;
                        end
                        // The partial-word check sees the lane after this cycle's byte.
                        if ((word_we && (word_count == LAST_WORD)) || load_end) begin
                            state      <= S_DONE;
                            byte_ready <= 1'b0;
                            load_done  <= 1'b1;
                            if (lane_after != 2'd0) begin
                                load_err <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                    cpu_hold   <= 1'b0;
                end
            endcase
        end
    end

    instruction_loader_inst_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (word_we),
        .waddr (word_count[ADDR_W-1:0]),
        .wdata (word_data),
        .raddr (pc[ADDR_W+1:2]),
        .rdata (inst)
    );

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: random byte streams checked against a
// byte-queue model of the loaded image.
module tb_instruction_loader;
    import instruction_loader_pkg::*;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [31:0]     pc = '0;
    logic [31:0]     inst;
    logic            load_start = 1'b0;
    logic            load_end = 1'b0;
    logic [7:0]      byte_in = '0;
    logic            byte_valid = 1'b0;
    logic            byte_ready;
    logic            cpu_hold;
    logic            load_done;
    logic            load_err;
    logic [ADDR_W:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [DEPTH];
    logic [7:0]  q [$];

    instruction_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .inst       (inst),
        .load_start (load_start),
        .load_end   (load_end),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_end();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    // Every complete group of four accepted bytes is one little-endian word.
    task automatic model_commit();
        for (int w = 0; w < q.size() / 4; w++)
            model_mem[w] = {q[4*w+3], q[4*w+2], q[4*w+1], q[4*w]};
    endtask

    // Word index plus random ignored address bits.
    task automatic point_pc(input int w);
        pc = ($urandom() & 32'hFFFF_FF03) | (32'(w) << 2);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks += 5;
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_byte_ready: got %b required 0", byte_ready); end
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL reset_cpu_hold: got %b required 0", cpu_hold); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL reset_load_done: got %b required 0", load_done); end
        if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err: got %b required 0", load_err); end
        if (word_count !== 7'd0) begin errors++; $display("FAIL reset_word_count: got %0d required 0", word_count); end
        rst_n = 1'b1;
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        checks += 2;
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL idle_byte_ready: got %b required 0", byte_ready); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL idle_end_ignored: got %b required 0", load_done); end
    endtask

    task automatic test_full();
        logic [7:0] b;
        pulse_start();
        q.delete();
        checks += 2;
        if (cpu_hold !== 1'b1) begin errors++; $display("FAIL full_hold_start: got %b required 1", cpu_hold); end
        if (byte_ready !== 1'b1) begin errors++; $display("FAIL full_ready_start: got %b required 1", byte_ready); end
        for (int i = 0; i < 4*DEPTH + 4; i++) begin
            b = 8'($urandom());
            send(b);
            if (i < 4*DEPTH) q.push_back(b);
            if (i == 4*DEPTH - 1) begin
                checks += 4;
                if (load_done !== 1'b1) begin errors++; $display("FAIL full_done: got %b required 1", load_done); end
                if (byte_ready !== 1'b0) begin errors++; $display("FAIL full_ready_drop: got %b required 0", byte_ready); end
                if (cpu_hold !== 1'b1) begin errors++; $display("FAIL full_hold_done: got %b required 1", cpu_hold); end
                if (word_count !== 7'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d required %0d", word_count, DEPTH); end
            end else if (i >= 4*DEPTH) begin
                checks += 3;
                if (byte_ready !== 1'b0) begin errors++; $display("FAIL full_extra_ready: got %b required 0", byte_ready); end
                if (load_done !== 1'b0) begin errors++; $display("FAIL full_extra_done: got %b required 0", load_done); end
                if (cpu_hold !== 1'b0) begin errors++; $display("FAIL full_extra_hold: got %b required 0", cpu_hold); end
            end
        end
        model_commit();
        checks += 2;
        if (word_count !== 7'(DEPTH)) begin errors++; $display("FAIL full_count_after: got %0d required %0d", word_count, DEPTH); end
        if (load_err !== 1'b0) begin errors++; $display("FAIL full_err: got %b required 0", load_err); end
        for (int w = 0; w < DEPTH; w++) begin
            point_pc(w);
            checks++;
            if (inst !== model_mem[w]) begin errors++; $display("FAIL full_word%0d: got %h required %h", w, inst, model_mem[w]); end
        end
        tick();
    endtask

    task automatic test_basic();
        int pulses;
        pulse_start();
        q.delete();
        send(8'h14); send(8'h00); send(8'hA0); send(8'hE3);
        q.push_back(8'h14); q.push_back(8'h00); q.push_back(8'hA0); q.push_back(8'hE3);
        checks++;
        if (word_count !== 7'd1) begin errors++; $display("FAIL basic_count_mid: got %0d required 1", word_count); end
        pulse_end();
        pulses = (load_done === 1'b1) ? 1 : 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (load_done === 1'b1) pulses++;
        end
        model_commit();
        point_pc(0);
        checks += 4;
        if (pulses != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d required 1", pulses); end
        if (word_count !== 7'd1) begin errors++; $display("FAIL basic_count: got %0d required 1", word_count); end
        if (load_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b required 0", load_err); end
        if (inst !== 32'hE3A00014) begin errors++; $display("FAIL basic_inst: got %h required e3a00014", inst); end
        tick();
    endtask

    task automatic test_toggle();
        logic [7:0] bytes [8] = '{8'h14, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h1A, 8'hA0, 8'hE3};
        int idx = 0;
        int hold_bad = 0;
        pulse_start();
        q.delete();
        for (int c = 0; c < 32 && idx < 8; c++) begin
            byte_in    = bytes[idx];
            byte_valid = (c % 2 == 0);
            tick();
            if (byte_valid) begin q.push_back(bytes[idx]); idx++; end
            if (cpu_hold !== 1'b1) hold_bad++;
        end
        byte_valid = 1'b0;
        pulse_end();
        checks += 4;
        if (idx != 8) begin errors++; $display("FAIL toggle_sent: got %0d required 8", idx); end
        if (hold_bad != 0) begin errors++; $display("FAIL toggle_hold_load: got %0d low cycles required 0", hold_bad); end
        if (load_done !== 1'b1) begin errors++; $display("FAIL toggle_done: got %b required 1", load_done); end
        if (cpu_hold !== 1'b1) begin errors++; $display("FAIL toggle_hold_done: got %b required 1", cpu_hold); end
        tick();
        model_commit();
        point_pc(1);
        checks += 3;
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL toggle_hold_idle: got %b required 0", cpu_hold); end
        if (word_count !== 7'd2) begin errors++; $display("FAIL toggle_count: got %0d required 2", word_count); end
        if (inst !== 32'hE3A01A01) begin errors++; $display("FAIL toggle_inst: got %h required e3a01a01", inst); end
        tick();
    endtask

    task automatic test_partial();
        logic [7:0] b;
        pulse_start();
        q.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom());
            send(b);
            q.push_back(b);
        end
        pulse_end();
        checks += 3;
        if (load_done !== 1'b1) begin errors++; $display("FAIL partial_done: got %b required 1", load_done); end
        if (load_err !== 1'b1) begin errors++; $display("FAIL partial_err: got %b required 1", load_err); end
        if (word_count !== 7'd1) begin errors++; $display("FAIL partial_count: got %0d required 1", word_count); end
        model_commit();
        for (int w = 0; w < 2; w++) begin
            point_pc(w);
            checks++;
            if (inst !== model_mem[w]) begin errors++; $display("FAIL partial_word%0d: got %h required %h", w, inst, model_mem[w]); end
        end
        repeat (2) tick();
        checks++;
        if (load_err !== 1'b1) begin errors++; $display("FAIL partial_err_sticky: got %b required 1", load_err); end
    endtask

    task automatic test_end_on_word();
        logic [7:0] b;
        pulse_start();
        q.delete();
        checks++;
        if (load_err !== 1'b0) begin errors++; $display("FAIL eow_err_cleared: got %b required 0", load_err); end
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom());
            q.push_back(b);
            load_end = (i == 7);
            send(b);
            load_end = 1'b0;
        end
        checks += 3;
        if (load_done !== 1'b1) begin errors++; $display("FAIL eow_done: got %b required 1", load_done); end
        if (load_err !== 1'b0) begin errors++; $display("FAIL eow_err: got %b required 0", load_err); end
        if (word_count !== 7'd2) begin errors++; $display("FAIL eow_count: got %0d required 2", word_count); end
        model_commit();
        for (int w = 0; w < 2; w++) begin
            point_pc(w);
            checks++;
            if (inst !== model_mem[w]) begin errors++; $display("FAIL eow_word%0d: got %h required %h", w, inst, model_mem[w]); end
        end
        tick();
    endtask

    task automatic test_restart();
        logic [7:0] b;
        pulse_start();
        q.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom());
            send(b);
            q.push_back(b);
        end
        model_commit();
        byte_in    = 8'($urandom());
        byte_valid = 1'b1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        byte_valid = 1'b0;
        checks += 3;
        if (word_count !== 7'd0) begin errors++; $display("FAIL restart_count: got %0d required 0", word_count); end
        if (cpu_hold !== 1'b1) begin errors++; $display("FAIL restart_hold: got %b required 1", cpu_hold); end
        if (byte_ready !== 1'b1) begin errors++; $display("FAIL restart_ready: got %b required 1", byte_ready); end
        q.delete();
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom());
            send(b);
            q.push_back(b);
        end
        pulse_end();
        checks += 2;
        if (word_count !== 7'd1) begin errors++; $display("FAIL restart_count_end: got %0d required 1", word_count); end
        if (load_err !== 1'b0) begin errors++; $display("FAIL restart_err: got %b required 0", load_err); end
        model_commit();
        for (int w = 0; w < 2; w++) begin
            point_pc(w);
            checks++;
            if (inst !== model_mem[w]) begin errors++; $display("FAIL restart_word%0d: got %h required %h", w, inst, model_mem[w]); end
        end
        tick();
    endtask

    task automatic test_reset_midload();
        logic [7:0] b;
        pulse_start();
        q.delete();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom());
            send(b);
            q.push_back(b);
        end
        model_commit();
        #2;
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b required 0", byte_ready); end
        if (cpu_hold !== 1'b0) begin errors++; $display("FAIL mid_rst_hold: got %b required 0", cpu_hold); end
        if (word_count !== 7'd0) begin errors++; $display("FAIL mid_rst_count: got %0d required 0", word_count); end
        if (load_err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b required 0", load_err); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL mid_rst_done: got %b required 0", load_done); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (byte_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_idle: got %b required 0", byte_ready); end
        for (int w = 0; w < 3; w++) begin
            point_pc(w);
            checks++;
            if (inst !== model_mem[w]) begin errors++; $display("FAIL mid_rst_word%0d: got %h required %h", w, inst, model_mem[w]); end
        end
    endtask

    initial begin
        test_reset();
        test_full();
        test_basic();
        test_toggle();
        test_partial();
        test_end_on_word();
        test_restart();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
